mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, memory access latency in cycles; legal range 1..15.
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width.
REQ-004 SHALL use one clock and an asynchronous, active-high reset, named as follows.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  instruction-fetch read request.
- i_adr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetch read data.
- i_ready  out  1  fetch completion pulse.
- d_req  in  1  data-stage request.
- d_we  in  1  data write enable; 0 means read.
- d_adr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  data write data.
- d_rdata  out  DATA_W  data read data.
- d_ready  out  1  data completion pulse.
- mem_en  out  1  memory port enable.
- mem_we  out  1  memory write enable.
- mem_adr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Function
REQ-005 SHALL arbitrate one single-port memory between the fetch port (I) and the data port (D) with FSM states IDLE, ACCESS and DONE.
REQ-006 SHALL, in IDLE when any req=1, latch the granted port's adr, we and wdata at the clock edge and enter ACCESS; if no req is high, it SHALL stay in IDLE.
REQ-007 SHALL grant D when both requests are high (fixed priority) unless REQ-019 applies.
REQ-008 SHALL hold ACCESS for exactly WAIT_CYCLES cycles using a down-counter loaded with WAIT_CYCLES-1 on entry.
REQ-009 SHALL drive mem_en=1 throughout ACCESS, mem_we=latched we throughout ACCESS, and mem_adr/mem_wdata from the latched values; all four outputs SHALL be 0 outside ACCESS.
REQ-010 SHALL capture mem_rdata at the edge ending the last ACCESS cycle into the granted port's rdata register.
REQ-011 SHALL, in DONE, pulse only the granted port's ready for exactly one cycle, then return to IDLE.
- A request-to-ready latency of WAIT_CYCLES+1 cycles follows from REQ-006, REQ-008 and REQ-011.
REQ-012 SHALL hold i_rdata/d_rdata stable from DONE until that port's next capture; write accesses SHALL leave rdata unchanged.
REQ-013 SHALL require requesters to hold req, adr, we and wdata until ready; if req drops mid-access, the access SHALL still complete and ready SHALL still pulse.
REQ-014 SHALL allow a new arbitration in IDLE on the cycle after DONE, which gives a minimum spacing of WAIT_CYCLES+2 cycles between grants.
REQ-015 SHALL never assert i_ready and d_ready in the same cycle.

Reset
REQ-016 SHALL, on reset assertion, immediately force state=IDLE, counter=0, mem_en=mem_we=0, mem_adr=mem_wdata=0, i_ready=d_ready=0 and i_rdata=d_rdata=0.
REQ-017 SHALL abort an access interrupted by reset, with no ready pulse afterwards; the first grant SHALL be sampled at the first rising edge after reset deasserts.

Configuration
REQ-018 SHALL compile round-robin arbitration in when the macro MEM_ARBITER_RR_EN is defined.
REQ-019 SHALL, with MEM_ARBITER_RR_EN defined, grant the port not granted last when both requests are high; a last-grant flop SHALL reset to I so that D wins first.
- Without MEM_ARBITER_RR_EN, fixed D priority applies, no last-grant flop exists, and I may starve.

Structure
REQ-020 SHALL take the FSM state enum (IDLE/ACCESS/DONE), the grant enum (GNT_I/GNT_D) and the WAIT_CYCLES default from the shared package mem_arbiter_pkg.
REQ-021 SHALL instantiate one sub-module, mem_arbiter_wait_cnt: a loadable 4-bit down-counter with a zero flag.

Verification
REQ-022 SHALL cover: reset=1 for 22 ns, then i_req=1 at i_adr=0 with mem_rdata=0xE04F000F -> mem_en high for 2 cycles, i_ready pulse in cycle 3, i_rdata=0xE04F000F.
REQ-023 SHALL cover: d_req=1, d_we=1, d_adr=100, d_wdata=7 -> mem_we=1, mem_adr=100, mem_wdata=7 for 2 cycles, one d_ready pulse, d_rdata unchanged.
REQ-024 SHALL cover: i_req and d_req raised on the same cycle -> D served first (d_ready), then I (i_ready) exactly 4 cycles later; with MEM_ARBITER_RR_EN and both held high, grants alternate D,I,D,I.
REQ-025 SHALL cover: reset asserted during the second ACCESS cycle of a write to 96 -> mem_we=0 immediately, no d_ready, state IDLE after reset releases.
REQ-026 SHALL cover: WAIT_CYCLES=1, d_req read of 100 -> d_ready 2 cycles after the request edge; d_req dropped mid-access with WAIT_CYCLES=3 -> d_ready still pulses once.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and defaults for the mem_arbiter block.
//   arbStateT : arbiter FSM states (IDLE / ACCESS / DONE)
//   grantT    : granted requester (GNT_I fetch port / GNT_D data port)
//   waitCyclesDefault : default memory access latency in cycles
//   cntWidth  : width of the access wait counter (WAIT_CYCLES legal range 1..15)
package mem_arbiter_pkg;

    localparam int unsigned waitCyclesDefault = 2;
    localparam int unsigned cntWidth          = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arbStateT;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grantT;

endpackage

// File: rtl/mem_arbiter_wait_cnt.sv
// mem_arbiter_wait_cnt: loadable down-counter timing the ACCESS phase.
// Ports:
//   clk, reset  rising-edge clock, asynchronous active-high reset
//   load        load loadVal into the counter (takes priority over dec)
//   loadVal     value loaded on entry to ACCESS
//   dec         decrement by one (saturates at zero)
//   zero        registered flag, high while the count is zero
module mem_arbiter_wait_cnt
    import mem_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [cntWidth-1:0] loadVal,
    input  logic                dec,
    output logic                zero
);

    logic [cntWidth-1:0] count;
    logic [cntWidth-1:0] countNext;

    // Next count: load wins, otherwise saturating decrement.
    always_comb begin
        countNext = count;
        if (load) begin
            countNext = loadVal;
        end else if (dec && (count != '0)) begin
            countNext = count - cntWidth'(1);
        end
    end

    // Zero flag is registered alongside the count so it always matches it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            zero  <= 1'b1;
        end else begin
            count <= countNext;
            zero  <= (countNext == '0);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction-fetch
// port (I, read only) and a data port (D, read/write).
// Each grant runs IDLE -> ACCESS (WAIT_CYCLES cycles) -> DONE (one-cycle ready).
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   i_req, i_adr                   fetch request and address
//   i_rdata, i_ready               fetch read data, completion pulse
//   d_req, d_we, d_adr, d_wdata    data request, write enable, address, write data
//   d_rdata, d_ready               data read data, completion pulse
//   mem_en, mem_we, mem_adr,
//   mem_wdata                      memory port (all zero outside ACCESS)
//   mem_rdata                      memory read data, sampled at end of ACCESS
// Build option: define MEM_ARBITER_RR_EN for round-robin arbitration when both
// ports request; otherwise D has fixed priority and I may starve.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = waitCyclesDefault,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_adr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_adr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arbStateT state, stateNext;
    grantT    grant, grantNext, pick;

    logic              memEnNext, memWeNext;
    logic [ADDR_W-1:0] memAdrNext;
    logic [DATA_W-1:0] memWdataNext;
    logic              iReadyNext, dReadyNext;
    logic [DATA_W-1:0] iRdataNext, dRdataNext;
    logic              cntLoad, cntDec, cntZero;

    mem_arbiter_wait_cnt uWaitCnt (
        .clk     (clk),
        .reset   (reset),
        .load    (cntLoad),
        .loadVal (cntWidth'(WAIT_CYCLES - 1)),
        .dec     (cntDec),
        .zero    (cntZero)
    );

    // Arbitration; the grant register doubles as the last-grant record and
    // resets to GNT_I, so D wins the first contested round.
    always_comb begin
`ifdef MEM_ARBITER_RR_EN
        if (i_req && d_req) begin
            pick = (grant == GNT_D) ? GNT_I : GNT_D;
        end else begin
            pick = d_req ? GNT_D : GNT_I;
        end
`else
        pick = d_req ? GNT_D : GNT_I;
`endif
    end

    // Next-state and next-output logic.
    always_comb begin
        stateNext    = state;
        grantNext    = grant;
        memEnNext    = 1'b0;
        memWeNext    = 1'b0;
        memAdrNext   = '0;
        memWdataNext = '0;
        iReadyNext   = 1'b0;
        dReadyNext   = 1'b0;
        iRdataNext   = i_rdata;
        dRdataNext   = d_rdata;
        cntLoad      = 1'b0;
        cntDec       = 1'b0;

        unique case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    stateNext = ACCESS;
                    grantNext = pick;
                    cntLoad   = 1'b1;
                    memEnNext = 1'b1;
                    // The memory port registers hold the latched request.
                    if (pick == GNT_D) begin
                        memWeNext    = d_we;
                        memAdrNext   = d_adr;
                        memWdataNext = d_wdata;
                    end else begin
                        memAdrNext   = i_adr;
                    end
                end
            end
            ACCESS: begin
                if (cntZero) begin
                    stateNext = DONE;
                    if (grant == GNT_D) begin
                        dReadyNext = 1'b1;
                        if (!mem_we) begin
                            dRdataNext = mem_rdata;
                        end
                    end else begin
                        iReadyNext = 1'b1;
                        iRdataNext = mem_rdata;
                    end
                end else begin
                    cntDec       = 1'b1;
                    memEnNext    = mem_en;
                    memWeNext    = mem_we;
                    memAdrNext   = mem_adr;
                    memWdataNext = mem_wdata;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= GNT_I;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            state     <= stateNext;
            grant     <= grantNext;
            mem_en    <= memEnNext;
            mem_we    <= memWeNext;
            mem_adr   <= memAdrNext;
            mem_wdata <= memWdataNext;
            i_ready   <= iReadyNext;
            d_ready   <= dReadyNext;
            i_rdata   <= iRdataNext;
            d_rdata   <= dRdataNext;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter.
// Three instances: 0 -> WAIT_CYCLES=2, 1 -> WAIT_CYCLES=1, 2 -> WAIT_CYCLES=3.
// Each issued request pushes its expected ready (instance, port, cycle, rdata)
// into a queue; a negedge monitor pops and compares on every ready pulse.
// Memory model: address 0 reads 0xE04F000F, any other address reads adr ^ 0xC0DE0000.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int          NI = 3;

    typedef struct {
        int          inst;
        bit          isD;
        logic [31:0] data;
        int          cyc;
    } expT;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic          iReq   [NI];
    logic [AW-1:0] iAdr   [NI];
    logic [DW-1:0] iRdata [NI];
    logic          iReady [NI];
    logic          dReq   [NI];
    logic          dWe    [NI];
    logic [AW-1:0] dAdr   [NI];
    logic [DW-1:0] dWdata [NI];
    logic [DW-1:0] dRdata [NI];
    logic          dReady [NI];
    logic          memEn  [NI];
    logic          memWe  [NI];
    logic [AW-1:0] memAdr [NI];
    logic [DW-1:0] memWdata[NI];
    logic [DW-1:0] memRdata[NI];

    expT expQ[$];
    expT mon;
    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;

    function automatic logic [31:0] memModel(input logic [31:0] a);
        return (a == 32'd0) ? 32'hE04F_000F : (a ^ 32'hC0DE_0000);
    endfunction

    function automatic int waitOf(input int inst);
        return (inst == 1) ? 1 : ((inst == 2) ? 3 : 2);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : gDut
        localparam int unsigned W = (g == 1) ? 1 : ((g == 2) ? 3 : 2);
        assign memRdata[g] = memModel(memAdr[g]);
        mem_arbiter #(.WAIT_CYCLES(W), .ADDR_W(AW), .DATA_W(DW)) uDut (
            .clk       (clk),
            .reset     (reset),
            .i_req     (iReq[g]),
            .i_adr     (iAdr[g]),
            .i_rdata   (iRdata[g]),
            .i_ready   (iReady[g]),
            .d_req     (dReq[g]),
            .d_we      (dWe[g]),
            .d_adr     (dAdr[g]),
            .d_wdata   (dWdata[g]),
            .d_rdata   (dRdata[g]),
            .d_ready   (dReady[g]),
            .mem_en    (memEn[g]),
            .mem_we    (memWe[g]),
            .mem_adr   (memAdr[g]),
            .mem_wdata (memWdata[g]),
            .mem_rdata (memRdata[g])
        );
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest expectation.
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            if (iReady[g] || dReady[g]) begin
                chk("ready_exclusive", 32'(iReady[g] & dReady[g]), 32'd0);
                if (expQ.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ready: inst %0d pulsed i=%0b d=%0b at cycle %0d, required no pulse",
                             g, iReady[g], dReady[g], cyc);
                end else begin
                    mon = expQ.pop_front();
                    chk("ready_inst", 32'(g), 32'(mon.inst));
                    chk("ready_port", 32'(dReady[g]), 32'(mon.isD));
                    chk("ready_cycle", 32'(cyc), 32'(mon.cyc));
                    chk("ready_rdata", mon.isD ? dRdata[g] : iRdata[g], mon.data);
                end
            end
        end
    end

    task automatic startReq(input int inst, input bit isD, input bit we, input logic [31:0] adr,
                            input logic [31:0] wd, input logic [31:0] expData, input int extra);
        expT e;
        if (isD) begin
            dReq[inst]   = 1'b1;
            dWe[inst]    = we;
            dAdr[inst]   = adr;
            dWdata[inst] = wd;
        end else begin
            iReq[inst] = 1'b1;
            iAdr[inst] = adr;
        end
        e.inst = inst;
        e.isD  = isD;
        e.data = expData;
        e.cyc  = cyc + waitOf(inst) + 1 + extra;
        expQ.push_back(e);
    endtask

    // Wait (bounded) for the port's ready, then drop its request.
    task automatic waitReady(input int inst, input bit isD);
        int n = 0;
        while (!(isD ? dReady[inst] : iReady[inst]) && (n < 40)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            tests++;
            fails++;
            $display("FAIL timeout: inst %0d port d=%0b got no ready in 40 cycles, required one", inst, isD);
        end
        if (isD) begin
            dReq[inst] = 1'b0;
            dWe[inst]  = 1'b0;
        end else begin
            iReq[inst] = 1'b0;
        end
    endtask

    initial begin
        for (int g = 0; g < NI; g++) begin
            iReq[g] = 1'b0; iAdr[g] = '0;
            dReq[g] = 1'b0; dWe[g] = 1'b0; dAdr[g] = '0; dWdata[g] = '0;
        end

        // Reset state
        #20;
        chk("rst_mem_en", 32'(memEn[0]), 32'd0);
        chk("rst_mem_adr", memAdr[0], 32'd0);
        chk("rst_i_ready", 32'(iReady[0]), 32'd0);
        chk("rst_i_rdata", iRdata[0], 32'd0);
        chk("rst_d_rdata", dRdata[0], 32'd0);
        #2 reset = 1'b0;
        @(negedge clk);

        // Fetch read of address 0: two ACCESS cycles, ready in cycle 3
        startReq(0, 1'b0, 1'b0, 32'd0, 32'd0, 32'hE04F_000F, 0);
        @(negedge clk);
        chk("t1_mem_en_a1", 32'(memEn[0]), 32'd1);
        chk("t1_mem_we_a1", 32'(memWe[0]), 32'd0);
        @(negedge clk);
        chk("t1_mem_en_a2", 32'(memEn[0]), 32'd1);
        @(negedge clk);
        chk("t1_mem_en_done", 32'(memEn[0]), 32'd0);
        waitReady(0, 1'b0);
        @(negedge clk);

        // Simultaneous requests: D first, I four cycles later
        startReq(0, 1'b1, 1'b0, 32'd100, 32'd0, 32'hC0DE_0064, 0);
        startReq(0, 1'b0, 1'b0, 32'd4,   32'd0, 32'hC0DE_0004, 4);
        waitReady(0, 1'b1);
        waitReady(0, 1'b0);
        @(negedge clk);

`ifdef MEM_ARBITER_RR_EN
        // Both held high: grants alternate D, I, D, I
        startReq(0, 1'b1, 1'b0, 32'd100, 32'd0, 32'hC0DE_0064, 0);
        startReq(0, 1'b0, 1'b0, 32'd4,   32'd0, 32'hC0DE_0004, 4);
        startReq(0, 1'b1, 1'b0, 32'd100, 32'd0, 32'hC0DE_0064, 8);
        startReq(0, 1'b0, 1'b0, 32'd4,   32'd0, 32'hC0DE_0004, 12);
        repeat (15) @(negedge clk);
        dReq[0] = 1'b0;
        iReq[0] = 1'b0;
        @(negedge clk);
`endif

        // Data write of 7 to 100: memory port driven, d_rdata untouched
        startReq(0, 1'b1, 1'b1, 32'd100, 32'd7, 32'hC0DE_0064, 0);
        @(negedge clk);
        chk("t2_mem_we_a1", 32'(memWe[0]), 32'd1);
        chk("t2_mem_adr_a1", memAdr[0], 32'd100);
        chk("t2_mem_wdata_a1", memWdata[0], 32'd7);
        @(negedge clk);
        chk("t2_mem_we_a2", 32'(memWe[0]), 32'd1);
        chk("t2_mem_wdata_a2", memWdata[0], 32'd7);
        @(negedge clk);
        chk("t2_mem_we_done", 32'(memWe[0]), 32'd0);
        chk("t2_i_rdata_stable", iRdata[0], 32'hC0DE_0004);
        waitReady(0, 1'b1);
        @(negedge clk);

        // Reset during the second ACCESS cycle of a write to 96: aborted, no ready
        dReq[0] = 1'b1; dWe[0] = 1'b1; dAdr[0] = 32'd96; dWdata[0] = 32'h55;
        @(negedge clk);
        @(negedge clk);
        chk("t4_mem_we_before", 32'(memWe[0]), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("t4_mem_we_reset", 32'(memWe[0]), 32'd0);
        chk("t4_mem_en_reset", 32'(memEn[0]), 32'd0);
        chk("t4_d_rdata_reset", dRdata[0], 32'd0);
        dReq[0] = 1'b0; dWe[0] = 1'b0;
        @(posedge clk);
        #3 reset = 1'b0;
        repeat (4) @(negedge clk);
        startReq(0, 1'b0, 1'b0, 32'd0, 32'd0, 32'hE04F_000F, 0);
        waitReady(0, 1'b0);
        @(negedge clk);

        // WAIT_CYCLES=1: read of 100, ready two cycles after the request edge
        startReq(1, 1'b1, 1'b0, 32'd100, 32'd0, 32'hC0DE_0064, 0);
        waitReady(1, 1'b1);
        @(negedge clk);

        // WAIT_CYCLES=3: d_req dropped mid-access, ready still pulses once
        startReq(2, 1'b1, 1'b0, 32'd200, 32'd0, 32'hC0DE_00C8, 0);
        @(negedge clk);
        dReq[2] = 1'b0;
        @(negedge clk);
        chk("t6_mem_en_held", 32'(memEn[2]), 32'd1);
        chk("t6_mem_adr_held", memAdr[2], 32'd200);
        waitReady(2, 1'b1);
        repeat (4) @(negedge clk);

        chk("queue_empty", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
